mov_slice_seq: RTL and testbench

- Parametrised, sequential successor to the single-bit MOV slice in the bit-slice ALU.
- Moves a WIDTH-bit operand through a SLICE-bit datapath, one slice per clock, least-significant slice first.
- Adds a small op set: move a, move inverted a, move b, clear.
- Uses valid/ready handshakes on both sides and sits between the operand register file and the ALU result bus.

---
 rtl/mov_slice_seq.sv | 125 ++++++++++++
 tb/tb_mov_slice_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mov_slice_seq.sv
// Sequential MOV slice: moves a WIDTH-bit operand through a SLICE-bit datapath,
// least-significant slice first, with valid/ready handshakes on both sides.
module mov_slice_seq #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_MOV  = 2'b00,
    OP_MOVN = 2'b01,
    OP_MOVB = 2'b10,
    OP_CLR  = 2'b11
  } op_t;

  state_t           state, state_nxt;
  op_t              op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [CW-1:0]    cnt;
  logic             last;

  assign last     = (cnt == CW'(NSLICE - 1));
  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (in_valid)  state_nxt = S_BUSY;
      S_BUSY:  if (last)      state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // Accumulator with the current slice merged in; constant slice offsets keep
  // the part-selects static while cnt picks which one is written.
  always_comb begin
    acc_nxt = acc;
    for (int s = 0; s < NSLICE; s++) begin
      if (cnt == CW'(s)) begin
        unique case (op_r)
          OP_MOV:  acc_nxt[s*SLICE +: SLICE] = a_r[s*SLICE +: SLICE];
          OP_MOVN: acc_nxt[s*SLICE +: SLICE] = ~a_r[s*SLICE +: SLICE];
          OP_MOVB: acc_nxt[s*SLICE +: SLICE] = b_r[s*SLICE +: SLICE];
          default: acc_nxt[s*SLICE +: SLICE] = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= OP_MOV;
      cnt       <= '0;
      acc       <= '0;
      out       <= '0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r  <= a;
            b_r  <= b;
            op_r <= op_t'(op);
            cnt  <= '0;
            acc  <= '0;
          end
        end
        S_BUSY: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          // out only ever sees the complete word, never a partial result
          if (last) begin
            out       <= acc_nxt;
            zero      <= (acc_nxt == '0);
            out_valid <= 1'b1;
            cnt       <= '0;
          end
        end
        S_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mov_slice_seq.sv
// Bench for mov_slice_seq: three instances (SLICE = 1, 4, 8 at WIDTH = 8),
// randomized ops checked against a word-level model of the op set.
module tb_mov_slice_seq;

  logic       clk = 1'b0;
  logic       rst_s       [3];
  logic       in_valid_s  [3];
  logic       in_ready_s  [3];
  logic [1:0] op_s        [3];
  logic [7:0] a_s         [3];
  logic [7:0] b_s         [3];
  logic [7:0] out_s       [3];
  logic       zero_s      [3];
  logic       out_valid_s [3];
  logic       out_ready_s [3];
  logic       busy_s      [3];

  logic [7:0] last_out [3];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mov_slice_seq #(.WIDTH(8), .SLICE(1)) u_s1 (
    .clk(clk), .rst(rst_s[0]), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .op(op_s[0]), .a(a_s[0]), .b(b_s[0]), .out(out_s[0]), .zero(zero_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .busy(busy_s[0]));

  mov_slice_seq #(.WIDTH(8), .SLICE(4)) u_s4 (
    .clk(clk), .rst(rst_s[1]), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .op(op_s[1]), .a(a_s[1]), .b(b_s[1]), .out(out_s[1]), .zero(zero_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .busy(busy_s[1]));

  mov_slice_seq #(.WIDTH(8), .SLICE(8)) u_s8 (
    .clk(clk), .rst(rst_s[2]), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
    .op(op_s[2]), .a(a_s[2]), .b(b_s[2]), .out(out_s[2]), .zero(zero_s[2]),
    .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]), .busy(busy_s[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nslice(input int k);
    case (k)
      0:       return 8;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  // Word-level meaning of each op.
  function automatic logic [7:0] ref_result(input logic [1:0] o, input logic [7:0] av,
                                            input logic [7:0] bv);
    case (o)
      2'd0:    return av;
      2'd1:    return 8'd255 - av;
      2'd2:    return bv;
      default: return 8'd0;
    endcase
  endfunction

  task automatic check_reset(input int k, input string tag);
    check({tag, "_out"},       out_s[k],       8'h00);
    check({tag, "_zero"},      zero_s[k],      1'b0);
    check({tag, "_out_valid"}, out_valid_s[k], 1'b0);
    check({tag, "_in_ready"},  in_ready_s[k],  1'b1);
    check({tag, "_busy"},      busy_s[k],      1'b0);
  endtask

  // One full transaction from IDLE; junk is driven on the inputs while busy.
  task automatic run_op(input int k, input logic [1:0] o, input logic [7:0] av,
                        input logic [7:0] bv, input int hold);
    logic [7:0] exp;
    int cyc;
    exp = ref_result(o, av, bv);
    check("idle_in_ready", in_ready_s[k], 1'b1);
    op_s[k] = o; a_s[k] = av; b_s[k] = bv;
    in_valid_s[k] = 1'b1; out_ready_s[k] = 1'b0;
    @(negedge clk);
    check("accept_busy", busy_s[k], 1'b1);
    cyc = 0;
    while (out_valid_s[k] !== 1'b1 && cyc < 64) begin
      check("busy_in_ready", in_ready_s[k], 1'b0);
      check("busy_out_hold", out_s[k], last_out[k]);
      in_valid_s[k]  = 1'($urandom_range(0, 1));
      op_s[k]        = 2'($urandom_range(0, 3));
      a_s[k]         = 8'($urandom);
      b_s[k]         = 8'($urandom);
      out_ready_s[k] = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, nslice(k));
    check("result", out_s[k], exp);
    check("zero", zero_s[k], exp == 8'd0);
    check("done_in_ready", in_ready_s[k], 1'b0);
    for (int h = 0; h < hold; h++) begin
      out_ready_s[k] = 1'b0;
      in_valid_s[k]  = 1'b1;
      a_s[k]         = 8'hFF;
      op_s[k]        = 2'($urandom_range(0, 3));
      @(negedge clk);
      check("bp_out_valid", out_valid_s[k], 1'b1);
      check("bp_out", out_s[k], exp);
      check("bp_in_ready", in_ready_s[k], 1'b0);
    end
    // Release with a competing request: it must not be taken on this edge.
    out_ready_s[k] = 1'b1;
    in_valid_s[k]  = 1'b1;
    a_s[k]         = 8'($urandom);
    @(negedge clk);
    check("rel_out_valid", out_valid_s[k], 1'b0);
    check("rel_in_ready", in_ready_s[k], 1'b1);
    check("rel_busy", busy_s[k], 1'b0);
    check("rel_out_kept", out_s[k], exp);
    last_out[k] = exp;
    in_valid_s[k]  = 1'b0;
    out_ready_s[k] = 1'b0;
  endtask

  task automatic reset_mid_op(input int k);
    op_s[k] = 2'd0; a_s[k] = 8'h81; in_valid_s[k] = 1'b1;
    @(negedge clk);
    in_valid_s[k] = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", busy_s[k], 1'b1);
    rst_s[k] = 1'b1;
    @(negedge clk);
    rst_s[k] = 1'b0;
    check_reset(k, "mid_rst");
    last_out[k] = 8'h00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", out_valid_s[k], 1'b0);
    end
    run_op(k, 2'd0, 8'h81, 8'h00, 0);
  endtask

  // in_valid and out_ready held high: an accept edge, NSLICE busy edges and
  // one DONE->IDLE edge separate consecutive accepts.
  task automatic back_to_back(input int k);
    logic       prev_busy;
    logic [7:0] drv, pend;
    int         last_acc, cyc;
    prev_busy = 1'b0; last_acc = -1; cyc = 0; pend = 8'h00;
    op_s[k] = 2'd0; out_ready_s[k] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid_s[k] = (i < 15);
      drv = 8'($urandom);
      a_s[k] = drv;
      @(negedge clk);
      cyc++;
      if (busy_s[k] && !prev_busy) begin
        if (last_acc >= 0) check("b2b_gap", cyc - last_acc, nslice(k) + 2);
        last_acc = cyc;
        pend = drv;
      end
      if (out_valid_s[k]) begin
        check("b2b_out", out_s[k], pend);
        last_out[k] = pend;
      end
      prev_busy = busy_s[k];
    end
    check("b2b_idle", busy_s[k], 1'b0);
    out_ready_s[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_s[k] = 1'b1; in_valid_s[k] = 1'b0; op_s[k] = 2'd0;
      a_s[k] = 8'h00; b_s[k] = 8'h00; out_ready_s[k] = 1'b0;
      last_out[k] = 8'h00;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;
    for (int k = 0; k < 3; k++) check_reset(k, "reset");

    run_op(0, 2'd0, 8'hA5, 8'h00, 0);
    run_op(1, 2'd1, 8'h3C, 8'h00, 0);
    run_op(1, 2'd2, 8'h00, 8'h7E, 0);
    run_op(1, 2'd3, 8'hA5, 8'h5A, 0);
    run_op(0, 2'd0, 8'h5A, 8'h00, 5);
    reset_mid_op(0);
    run_op(2, 2'd0, 8'h01, 8'h00, 0);
    back_to_back(2);

    for (int k = 0; k < 3; k++)
      for (int n = 0; n < 20; n++)
        run_op(k, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
               $urandom_range(0, 3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
